exp_frac_combine: RTL



---
 rtl/exp_frac_combine.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/exp_frac_combine.sv
// Sequential exp(x) evaluator: LUT integer part times a Horner Taylor series of the fraction.
// Define EXP_ROUND_EN to round the final Q14.18 product half-up instead of truncating.
module exp_frac_combine #(
  parameter int TERMS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_x,
  output logic        [5:0]  lut_int_part,
  input  logic        [31:0] lut_exp_int,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [31:0] out_y,
  output logic               out_ovf
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] POLY = 3'd2;
  localparam logic [2:0] MUL  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [19:0] ONE_Q18 = 20'd262144;

  logic [2:0]  state_q, state_d;
  logic [5:0]  lut_int_part_q, lut_int_part_d;
  logic [17:0] f_q, f_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  k_q, k_d;
  logic [31:0] exp_int_q, exp_int_d;
  logic        lut_sat_q, lut_sat_d;
  logic [31:0] out_y_q, out_y_d;
  logic        out_ovf_q, out_ovf_d;

  // 1/k in Q0.18
  function automatic logic [18:0] recip(input logic [3:0] k);
    case (k)
      4'd1:    recip = 19'd262144;
      4'd2:    recip = 19'd131072;
      4'd3:    recip = 19'd87381;
      4'd4:    recip = 19'd65536;
      4'd5:    recip = 19'd52429;
      4'd6:    recip = 19'd43691;
      4'd7:    recip = 19'd37449;
      4'd8:    recip = 19'd32768;
      default: recip = 19'd0;
    endcase
  endfunction

  function automatic logic [19:0] horner_step(input logic [19:0] acc,
                                              input logic [17:0] f,
                                              input logic [3:0]  k);
    logic [37:0] af;
    logic [19:0] t1;
    logic [38:0] tr;
    af = {18'b0, acc} * {20'b0, f};
    t1 = 20'(af >> 18);
    tr = {19'b0, t1} * {20'b0, recip(k)};
    horner_step = ONE_Q18 + 20'(tr >> 18);
  endfunction

  // Returns {ovf, y}; a saturated LUT entry or a product beyond 32 bits clamps to all-ones.
  function automatic logic [32:0] sat_mul(input logic [31:0] exp_int,
                                          input logic [19:0] acc,
                                          input logic        sat);
    logic [51:0] p;
    logic [52:0] pr;
    logic [34:0] r;
    p = {20'b0, exp_int} * {32'b0, acc};
`ifdef EXP_ROUND_EN
    pr = {1'b0, p} + 53'd131072;
`else
    pr = {1'b0, p};
`endif
    r = 35'(pr >> 18);
    if (sat || (|r[34:32])) sat_mul = {1'b1, 32'hFFFF_FFFF};
    else                    sat_mul = {1'b0, r[31:0]};
  endfunction

  always_comb begin
    state_d        = state_q;
    lut_int_part_d = lut_int_part_q;
    f_d            = f_q;
    acc_d          = acc_q;
    k_d            = k_q;
    exp_int_d      = exp_int_q;
    lut_sat_d      = lut_sat_q;
    out_y_d        = out_y_q;
    out_ovf_d      = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lut_int_part_d = in_x[15:10];
          f_d            = {in_x[9:0], 8'b0};
          acc_d          = ONE_Q18;
          k_d            = 4'(TERMS);
          state_d        = LOAD;
        end
      end
      LOAD: begin
        exp_int_d = lut_exp_int;
        lut_sat_d = (lut_exp_int == 32'hFFFF_FFFF);
        state_d   = POLY;
      end
      POLY: begin
        acc_d = horner_step(acc_q, f_q, k_q);
        k_d   = k_q - 4'd1;
        if (k_q == 4'd1) state_d = MUL;
      end
      MUL: begin
        {out_ovf_d, out_y_d} = sat_mul(exp_int_q, acc_q, lut_sat_q);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lut_int_part_q <= '0;
      f_q            <= '0;
      acc_q          <= '0;
      k_q            <= '0;
      exp_int_q      <= '0;
      lut_sat_q      <= 1'b0;
      out_y_q        <= '0;
      out_ovf_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lut_int_part_q <= lut_int_part_d;
      f_q            <= f_d;
      acc_q          <= acc_d;
      k_q            <= k_d;
      exp_int_q      <= exp_int_d;
      lut_sat_q      <= lut_sat_d;
      out_y_q        <= out_y_d;
      out_ovf_q      <= out_ovf_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign lut_int_part = lut_int_part_q;
  assign out_y        = out_y_q;
  assign out_ovf      = out_ovf_q;

endmodule
